cp0_except_ctrl: RTL and testbench

Exception and interrupt sequencer for the CP0 coprocessor. It samples MEM-stage exception flags, ERET, and interrupt sources, then selects the winning event by fixed priority. It issues the one-cycle exception request that makes CP0 record EPC, BD and ExcCode. It then drains the pipeline and redirects fetch to the exception vector or the ERET target.

---
 rtl/cp0_except_ctrl_if.sv | 41 ++++
 rtl/cp0_except_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cp0_except_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_except_ctrl_if.sv
// Bus between the MEM stage / CP0 register file and the exception sequencer.
// master = pipeline/CP0 side, slave = cp0_except_ctrl.
interface cp0_except_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_delayslot;
  logic [6:0]  mem_exc;
  logic        mem_eret;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status;
  logic [1:0]  cp0_cause_sw;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_count;
  logic [31:0] cp0_compare;
  logic        compare_we;

  logic        except_flush;
  logic [4:0]  except_code;
  logic [31:0] except_pc;
  logic        except_delayslot;
  logic        eret_commit;
  logic [5:0]  ip_hw;
  logic        pipe_flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_valid, mem_pc, mem_delayslot, mem_exc, mem_eret, hw_int,
           cp0_status, cp0_cause_sw, cp0_epc, cp0_count, cp0_compare, compare_we,
    input  except_flush, except_code, except_pc, except_delayslot, eret_commit,
           ip_hw, pipe_flush, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_valid, mem_pc, mem_delayslot, mem_exc, mem_eret, hw_int,
           cp0_status, cp0_cause_sw, cp0_epc, cp0_count, cp0_compare, compare_we,
    output except_flush, except_code, except_pc, except_delayslot, eret_commit,
           ip_hw, pipe_flush, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_except_ctrl.sv
// CP0 exception/interrupt sequencer: priority select, drain, fetch redirect.
// Define CP0_TIMER_INT_EN to drive ip_hw[5] from the Count/Compare timer latch.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  cp0_except_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REDIRECT} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

`ifdef CP0_TIMER_INT_EN
  localparam int unsigned SYNC_W = 5;
`else
  localparam int unsigned SYNC_W = 6;
`endif

  state_t      r_state, w_state_nx;
  logic [3:0]  r_drain_cnt, w_drain_cnt_nx;
  logic [31:0] r_target, w_target_nx;

  logic [SYNC_W-1:0] r_hw_s1, r_hw_s2;
  logic [5:0]        w_ip_hw;
  logic              w_int_req;
  logic              w_exc_hit;
  logic [4:0]        w_exc_code;
  logic              w_exc_take;
  logic              w_eret_take;
  logic              w_unused_bits;

  logic        w_except_flush;
  logic [4:0]  w_except_code;
  logic        w_eret_commit;
  logic        w_pipe_flush;
  logic        w_stall;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hw_s1 <= '0;
      r_hw_s2 <= '0;
    end else begin
      r_hw_s1 <= bus.hw_int[SYNC_W-1:0];
      r_hw_s2 <= r_hw_s1;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic r_timer;

  // Clear has priority so a Compare write in the match cycle acknowledges it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= 1'b0;
    end else if (bus.compare_we) begin
      r_timer <= 1'b0;
    end else if (bus.cp0_count == bus.cp0_compare) begin
      r_timer <= 1'b1;
    end
  end

  assign w_ip_hw       = {r_timer, r_hw_s2};
  assign w_unused_bits = ^{bus.hw_int[5], bus.cp0_status[31:16], bus.cp0_status[7:2]};
`else
  assign w_ip_hw       = r_hw_s2;
  assign w_unused_bits = ^{bus.cp0_count, bus.cp0_compare, bus.compare_we,
                           bus.cp0_status[31:16], bus.cp0_status[7:2]};
`endif

  assign w_int_req = bus.mem_valid && bus.cp0_status[0] && !bus.cp0_status[1] &&
                     (({w_ip_hw, bus.cp0_cause_sw} & bus.cp0_status[15:8]) != 8'h00);

  always_comb begin
    w_exc_hit  = 1'b1;
    w_exc_code = '0;
    if (w_int_req)           w_exc_code = 5'd0;
    else if (bus.mem_exc[0]) w_exc_code = 5'd4;
    else if (bus.mem_exc[1]) w_exc_code = 5'd10;
    else if (bus.mem_exc[2]) w_exc_code = 5'd8;
    else if (bus.mem_exc[3]) w_exc_code = 5'd9;
    else if (bus.mem_exc[4]) w_exc_code = 5'd12;
    else if (bus.mem_exc[5]) w_exc_code = 5'd4;
    else if (bus.mem_exc[6]) w_exc_code = 5'd5;
    else                     w_exc_hit  = 1'b0;
  end

  // Events are suppressed while reset is asserted so every output reads 0.
  assign w_exc_take  = rst_n && bus.mem_valid && w_exc_hit;
  assign w_eret_take = rst_n && bus.mem_valid && bus.mem_eret && !w_exc_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_target    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_drain_cnt <= w_drain_cnt_nx;
      r_target    <= w_target_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_drain_cnt_nx = r_drain_cnt;
    w_target_nx    = r_target;
    case (r_state)
      S_IDLE: begin
        if (w_exc_take) begin
          w_state_nx     = S_DRAIN;
          w_drain_cnt_nx = DRAIN_INIT;
          w_target_nx    = EXC_VECTOR;
        end else if (w_eret_take) begin
          w_state_nx     = S_DRAIN;
          w_drain_cnt_nx = DRAIN_INIT;
          w_target_nx    = bus.cp0_epc;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 4'd0) w_state_nx = S_REDIRECT;
        else                     w_drain_cnt_nx = r_drain_cnt - 4'd1;
      end
      S_REDIRECT: w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_except_flush   = 1'b0;
    w_except_code    = '0;
    w_eret_commit    = 1'b0;
    w_pipe_flush     = 1'b0;
    w_stall          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    case (r_state)
      S_IDLE: begin
        w_except_flush = w_exc_take;
        w_except_code  = w_exc_take ? w_exc_code : 5'd0;
        w_eret_commit  = w_eret_take;
        w_pipe_flush   = w_exc_take || w_eret_take;
      end
      S_DRAIN: begin
        w_stall      = 1'b1;
        w_pipe_flush = 1'b1;
      end
      S_REDIRECT: begin
        w_redirect_valid = 1'b1;
        w_redirect_pc    = r_target;
      end
      default: ;
    endcase
  end

  assign bus.except_flush     = w_except_flush;
  assign bus.except_code      = w_except_code;
  assign bus.except_pc        = rst_n ? bus.mem_pc : '0;
  assign bus.except_delayslot = rst_n && bus.mem_delayslot;
  assign bus.eret_commit      = w_eret_commit;
  assign bus.ip_hw            = w_ip_hw;
  assign bus.pipe_flush       = w_pipe_flush;
  assign bus.stall            = w_stall;
  assign bus.redirect_valid   = w_redirect_valid;
  assign bus.redirect_pc      = w_redirect_pc;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Self-checking bench for cp0_except_ctrl against a timeline-based reference model.
module tb_cp0_except_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_except_ctrl_if bus ();

  cp0_except_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        flush;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        ds;
    logic        eret;
    logic [5:0]  ip;
    logic        pflush;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: event cycle, latched target, interrupt-line history, timer.
  int          cyc  = 0;
  int          ev_t = -100;
  logic [31:0] tgt  = '0;
  logic [5:0]  hw_hist [2] = '{6'd0, 6'd0};
  logic        tmr  = 1'b0;

  function automatic logic [5:0] ip_model();
`ifdef CP0_TIMER_INT_EN
    return {tmr, hw_hist[1][4:0]};
`else
    return hw_hist[1];
`endif
  endfunction

  function automatic out_t model_out();
    out_t        o;
    int          d;
    logic [5:0]  ip;
    logic        irq;
    int unsigned codes [7];
    codes = '{4, 10, 8, 9, 12, 4, 5};
    o  = '0;
    d  = cyc - ev_t;
    ip = ip_model();
    o.ip = ip;
    if (rst_n) begin
      o.epc = bus.mem_pc;
      o.ds  = bus.mem_delayslot;
    end
    if (d >= 1 && d <= D) begin
      o.stall  = 1'b1;
      o.pflush = 1'b1;
    end else if (d == D + 1) begin
      o.rv  = 1'b1;
      o.rpc = tgt;
    end else if (rst_n && bus.mem_valid) begin
      irq = bus.cp0_status[0] && !bus.cp0_status[1] &&
            (({ip, bus.cp0_cause_sw} & bus.cp0_status[15:8]) != 8'h00);
      if (irq) o.flush = 1'b1;
      else begin
        for (int i = 0; i < 7; i++) begin
          if (bus.mem_exc[i] && !o.flush) begin
            o.flush = 1'b1;
            o.code  = 5'(codes[i]);
          end
        end
      end
      if (o.flush) o.pflush = 1'b1;
      else if (bus.mem_eret) begin
        o.eret   = 1'b1;
        o.pflush = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    return {bus.except_flush, bus.except_code, bus.except_pc, bus.except_delayslot,
            bus.eret_commit, bus.ip_hw, bus.pipe_flush, bus.stall,
            bus.redirect_valid, bus.redirect_pc};
  endfunction

  always @(posedge clk) begin : model_step
    out_t e;
    e = model_out();
    if (!rst_n) begin
      ev_t = -100;
      tgt  = '0;
      hw_hist[0] = '0;
      hw_hist[1] = '0;
      tmr  = 1'b0;
    end else begin
      if (e.flush || e.eret) begin
        ev_t = cyc;
        tgt  = e.flush ? VEC : bus.cp0_epc;
      end
      hw_hist[1] = hw_hist[0];
      hw_hist[0] = bus.hw_int;
      if (bus.compare_we) tmr = 1'b0;
      else if (bus.cp0_count == bus.cp0_compare) tmr = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid     = 1'b0;
    bus.mem_pc        = '0;
    bus.mem_delayslot = 1'b0;
    bus.mem_exc       = '0;
    bus.mem_eret      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.hw_int = '0; bus.cp0_status = '0; bus.cp0_cause_sw = '0; bus.cp0_epc = '0;
    bus.cp0_count = 32'd1; bus.cp0_compare = 32'd0; bus.compare_we = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
      end
      n_vec++;
      if (dut_out() !== out_t'(0)) begin
        n_err++; $display("FAIL reset_zero got=%h exp=0", dut_out());
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ov();
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h8000_0100; bus.mem_delayslot = 1'b1;
    bus.mem_exc = 7'h10;
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL ov_T got=%h exp=%h", dut_out(), model_out());
    end
    n_vec++;
    if ({bus.except_flush, bus.except_code, bus.except_pc, bus.except_delayslot} !==
        {1'b1, 5'd12, 32'h8000_0100, 1'b1}) begin
      n_err++; $display("FAIL ov_fields got=%b/%0d/%h/%b exp=1/12/80000100/1",
                        bus.except_flush, bus.except_code, bus.except_pc, bus.except_delayslot);
    end
    tick(); idle_inputs();
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL ov_T+%0d got=%h exp=%h", k, dut_out(), model_out());
      end
      n_vec++;
      if (k <= D && bus.stall !== 1'b1) begin
        n_err++; $display("FAIL ov_stall T+%0d got=%b exp=1", k, bus.stall);
      end
      if (k == D + 1 && {bus.redirect_valid, bus.redirect_pc} !== {1'b1, VEC}) begin
        n_err++; $display("FAIL ov_redirect got=%b/%h exp=1/%h", bus.redirect_valid, bus.redirect_pc, VEC);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h8000_0040; bus.mem_exc = 7'h12;
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL prio got=%h exp=%h", dut_out(), model_out());
    end
    n_vec++;
    if (bus.except_code !== 5'd10) begin
      n_err++; $display("FAIL prio_code got=%0d exp=10", bus.except_code);
    end
    tick(); idle_inputs();
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL prio_drain got=%h exp=%h", dut_out(), model_out());
      end
      tick();
    end
  endtask

  task automatic test_interrupt();
    bus.cp0_status = 32'h0000_1001;
    bus.hw_int = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL irq_sync k=%0d got=%h exp=%h", k, dut_out(), model_out());
      end
      tick();
    end
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h8000_0300; bus.mem_exc = 7'h10;
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL irq_T got=%h exp=%h", dut_out(), model_out());
    end
    n_vec++;
    if ({bus.except_flush, bus.except_code, bus.ip_hw[2]} !== {1'b1, 5'd0, 1'b1}) begin
      n_err++; $display("FAIL irq_code got=%b/%0d/%b exp=1/0/1", bus.except_flush, bus.except_code, bus.ip_hw[2]);
    end
    tick(); idle_inputs();
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL irq_drain got=%h exp=%h", dut_out(), model_out());
      end
      tick();
    end
    bus.cp0_status = 32'h0000_1003;
    bus.mem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL irq_exl got=%h exp=%h", dut_out(), model_out());
      end
      n_vec++;
      if (bus.except_flush !== 1'b0) begin
        n_err++; $display("FAIL irq_exl_flush got=%b exp=0", bus.except_flush);
      end
      tick();
    end
    idle_inputs(); bus.hw_int = '0; bus.cp0_status = '0;
    tick(); tick();
  endtask

  task automatic test_eret();
    bus.cp0_epc = 32'h8000_0200;
    bus.mem_valid = 1'b1; bus.mem_eret = 1'b1; bus.mem_pc = 32'h8000_0500;
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL eret_T got=%h exp=%h", dut_out(), model_out());
    end
    n_vec++;
    if ({bus.eret_commit, bus.except_flush} !== 2'b10) begin
      n_err++; $display("FAIL eret_pulse got=%b%b exp=10", bus.eret_commit, bus.except_flush);
    end
    tick();
    bus.mem_eret = 1'b0; bus.mem_exc = 7'h04;
    for (int k = 1; k <= D + 1; k++) begin
      if (k == D + 1) idle_inputs();
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL eret_T+%0d got=%h exp=%h", k, dut_out(), model_out());
      end
      n_vec++;
      if (bus.except_flush !== 1'b0 || bus.eret_commit !== 1'b0) begin
        n_err++; $display("FAIL eret_once got=%b%b exp=00", bus.except_flush, bus.eret_commit);
      end
      if (k == D + 1 && bus.redirect_pc !== 32'h8000_0200) begin
        n_err++; $display("FAIL eret_target got=%h exp=80000200", bus.redirect_pc);
      end
      tick();
    end
  endtask

  task automatic test_ip5();
`ifdef CP0_TIMER_INT_EN
    // match; write-clear; match together with write
    logic [31:0] cnt_v [3];
    logic        we_v  [3];
    logic        exp5  [3];
    cnt_v = '{32'd7, 32'd9, 32'd7}; we_v = '{1'b0, 1'b1, 1'b1}; exp5 = '{1'b1, 1'b0, 1'b0};
    bus.cp0_compare = 32'd7;
    for (int k = 0; k < 3; k++) begin
      bus.cp0_count = cnt_v[k]; bus.compare_we = we_v[k];
      tick();
      bus.cp0_count = 32'd100; bus.compare_we = 1'b0;
      @(negedge clk); n_vec++;
      if (bus.ip_hw[5] !== exp5[k]) begin
        n_err++; $display("FAIL timer k=%0d got=%b exp=%b", k, bus.ip_hw[5], exp5[k]);
      end
      n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL timer_model got=%h exp=%h", dut_out(), model_out());
      end
      tick();
    end
`else
    bus.hw_int = 6'b100000;
    tick(); tick();
    @(negedge clk); n_vec++;
    if (bus.ip_hw[5] !== 1'b1) begin
      n_err++; $display("FAIL hw5 got=%b exp=1", bus.ip_hw[5]);
    end
    bus.hw_int = '0;
    tick(); tick();
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL hw5_model got=%h exp=%h", dut_out(), model_out());
    end
    tick();
`endif
  endtask

  task automatic test_reset_in_drain();
    bus.mem_valid = 1'b1; bus.mem_exc = 7'h08; bus.mem_pc = 32'h8000_0700;
    tick(); idle_inputs();
    rst_n = 1'b0;
    @(negedge clk); n_vec++;
    if (dut_out() !== model_out()) begin
      n_err++; $display("FAIL rstdrain_pre got=%h exp=%h", dut_out(), model_out());
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < D + 3; k++) begin
      @(negedge clk); n_vec++;
      if (dut_out() !== out_t'(0)) begin
        n_err++; $display("FAIL rstdrain k=%0d got=%h exp=0", k, dut_out());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int last = -1000;
    for (int k = 0; k < 24; k++) begin
      bus.mem_valid = 1'b1; bus.mem_pc = $urandom; bus.mem_delayslot = 1'($urandom);
      bus.mem_exc = 7'($urandom_range(1, 127)); bus.mem_eret = 1'($urandom);
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL b2b k=%0d got=%h exp=%h", k, dut_out(), model_out());
      end
      if (bus.except_flush === 1'b1) begin
        n_vec++;
        if (cyc - last < D + 2) begin
          n_err++; $display("FAIL b2b_spacing got=%0d exp>=%0d", cyc - last, D + 2);
        end
        last = cyc;
      end
      tick();
    end
    idle_inputs();
    repeat (D + 2) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.mem_valid     = 1'($urandom);
      bus.mem_pc        = $urandom;
      bus.mem_delayslot = 1'($urandom);
      bus.mem_exc       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      bus.mem_eret      = ($urandom_range(0, 3) == 0);
      bus.hw_int        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.cp0_status    = {16'd0, 8'($urandom), 6'd0, 2'($urandom)};
      bus.cp0_cause_sw  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      bus.cp0_epc       = $urandom;
      bus.cp0_count     = 32'($urandom_range(0, 3));
      bus.cp0_compare   = 32'($urandom_range(0, 3));
      bus.compare_we    = ($urandom_range(0, 3) == 0);
      @(negedge clk); n_vec++;
      if (dut_out() !== model_out()) begin
        n_err++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_out(), model_out());
      end
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ov();
    test_priority();
    test_interrupt();
    test_eret();
    test_ip5();
    test_reset_in_drain();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
